led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Sits between the SPI byte receiver and the tt_um_rgbled serial LED driver.
- Assembles a byte stream into a full LED frame and stages it double-buffered.
- Launches the frame to the driver with a one-cycle data_rdy pulse, then enforces the transmit-plus-latch dwell time before the next launch.
- Optionally re-sends the last frame on a periodic refresh timer.

Parameters:
- NUM_LEDS, 3, number of chained LEDs.
- BITS_PER_LED, 24, colour bits per LED (GRB). Must be a multiple of 8.
- TX_CYCLES, 1500, clk cycles the driver needs for one full frame plus latch/reset gap.
- REFRESH_CYCLES, 0, idle cycles after which the current frame is re-sent. 0 disables refresh.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse, SPI chip-select asserted; starts a new frame.
- frame_end  in  1  pulse, SPI chip-select released; closes the frame.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  received byte.
- data  out  NUM_LEDS*BITS_PER_LED  frame to driver; held stable while busy.
- data_rdy  out  1  one-cycle launch pulse to driver.
- busy  out  1  high while the dwell counter runs.
- err_short  out  1  one-cycle pulse: frame closed with too few bytes.
- err_long  out  1  one-cycle pulse: frame closed after overflow bytes.

Behaviour:
- Width rules: FRAME_BYTES = NUM_LEDS*BITS_PER_LED/8.
- Byte counter width is clog2(FRAME_BYTES+1), saturating at FRAME_BYTES.
- Dwell counter width is clog2(max(TX_CYCLES, REFRESH_CYCLES)+1).
- Reset values: data=0, data_rdy=0, busy=0, err_short=0, err_long=0. Shadow buffer, staged buffer, pending flag, overflow flag and all counters clear. FSM goes to IDLE.
- Byte collection (runs independently of the FSM):
  - frame_start clears the byte counter and the overflow flag.
  - Each byte_valid with counter < FRAME_BYTES writes shadow byte[counter], then increments the counter.
  - Byte 0 lands in data MSBs, i.e. LED0 G[7:0].
  - byte_valid with counter == FRAME_BYTES sets the overflow flag; the byte is dropped.
- Same-cycle input events:
  - frame_start with byte_valid: the counter clears and the byte is stored at index 0.
  - byte_valid with frame_end: the byte is stored first, then the frame is evaluated including it.
- On frame_end:
  - count == FRAME_BYTES and no overflow: staged <= shadow (including a same-cycle byte), pending <= 1. A newer valid frame overwrites an older un-launched one (latest wins).
  - count < FRAME_BYTES: err_short pulses next cycle; staged and pending are unchanged.
  - overflow set: err_long pulses next cycle; frame discarded.
- FSM IDLE:
  - If pending: data <= staged, data_rdy pulses one cycle, pending clears, dwell counter loads TX_CYCLES-1, busy=1, go to BUSY.
  - Else if REFRESH_CYCLES>0 and the idle counter reaches REFRESH_CYCLES-1: relaunch data unchanged, with the same pulse/load/busy behaviour as a pending launch.
  - The idle counter runs only in IDLE and clears on every launch.
- FSM BUSY:
  - The dwell counter decrements.
  - At 0: busy=0 and go to IDLE. A pending frame then launches on the following cycle at the earliest, so back-to-back launches are exactly TX_CYCLES+1 cycles apart.
  - frame_end during BUSY only stages the frame and sets pending; data never changes in BUSY.
- Launch latency: frame_end of a valid frame while IDLE gives data_rdy exactly 2 cycles later (staging cycle, then launch cycle).
- Pending set on a launch cycle is honoured after the next dwell.
- reset mid-frame or mid-BUSY: immediate return to reset state; partial frames are lost; data goes to 0.
- data_rdy and the error pulses never exceed one cycle.

Decomposition:
- Shared package led_pkg holds:
  - constants FRAME_BYTES and the default TX_CYCLES;
  - the state enum {IDLE, BUSY};
  - a function computing frame width from NUM_LEDS/BITS_PER_LED.
- One sub-module is natural: led_frame_assembler, covering the byte counter, shadow/staged buffers, pending flag and error pulses.
- The FSM and dwell/refresh counters stay in the top module.

Test Plan:
- Bench parameters: NUM_LEDS=3, BITS_PER_LED=24, TX_CYCLES=20.
- Valid frame: start, 9 bytes 0x01..0x09, end while IDLE -> data_rdy exactly 2 cycles after end, data=0x010203040506070809, busy high 20 cycles.
- Short frame: start, 5 bytes, end -> err_short pulses 1 cycle, no data_rdy, data unchanged.
- Long frame: start, 10 bytes, end -> err_long pulse, no launch, data unchanged.
- Frames during BUSY: two valid frames A, B completed during BUSY -> after busy falls, one launch with data=B; launches spaced 21 cycles; A never appears.
- Refresh: REFRESH_CYCLES=50, one valid frame, then idle -> data_rdy repeats every 71 cycles with identical data. With REFRESH_CYCLES=0 there is no repeat.
- Reset and simultaneity: reset asserted mid-BUSY and mid-frame -> next cycle data=0, busy=0, no pulses. A new full frame then launches normally. A byte_valid coincident with frame_end as the 9th byte is accepted as a valid frame.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants, FSM state type and frame-width helper for the LED frame scheduler.
package led_pkg;

  localparam int DEF_NUM_LEDS     = 3;
  localparam int DEF_BITS_PER_LED = 24;
  localparam int DEF_TX_CYCLES    = 1500;
  localparam int FRAME_BYTES      = DEF_NUM_LEDS * DEF_BITS_PER_LED / 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } led_state_e;

  function automatic int frame_width(input int num_leds, input int bits_per_led);
    return num_leds * bits_per_led;
  endfunction

endpackage

// File: rtl/led_frame_assembler.sv
// Collects SPI bytes into a shadow frame, stages complete frames for launch and
// flags frames closed short or after overflow.
module led_frame_assembler
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int BITS_PER_LED = DEF_BITS_PER_LED,
  localparam int FW          = frame_width(NUM_LEDS, BITS_PER_LED)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  input  logic          take,
  output logic [FW-1:0] staged,
  output logic          pending,
  output logic          err_short,
  output logic          err_long
);

  localparam int FB = FW / 8;
  localparam int CW = $clog2(FB + 1);
  localparam logic [CW-1:0] FB_C = CW'(FB);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_next;
  logic          ovf;
  logic          ovf_base;
  logic          ovf_next;
  logic          store;
  logic          frame_ok;
  logic [FW-1:0] shadow;
  logic [FW-1:0] shadow_next;

  // A same-cycle frame_start restarts the frame before the byte lands; a
  // same-cycle frame_end sees the frame including that byte.
  always_comb begin
    cnt_base    = frame_start ? CW'(0) : cnt;
    ovf_base    = frame_start ? 1'b0 : ovf;
    store       = byte_valid && (cnt_base < FB_C);
    shadow_next = shadow;
    for (int i = 0; i < FB; i++) begin
      shadow_next[FW-1-8*i -: 8] = (store && (cnt_base == CW'(i))) ? byte_data
                                                                    : shadow[FW-1-8*i -: 8];
    end
    cnt_next = store ? (cnt_base + CW'(1)) : cnt_base;
    ovf_next = ovf_base | (byte_valid & (cnt_base == FB_C));
    frame_ok = frame_end & ~ovf_next & (cnt_next == FB_C);
  end

  // Byte capture, staging and error pulses; a new frame's pending beats a launch take.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= CW'(0);
      ovf       <= 1'b0;
      shadow    <= {FW{1'b0}};
      staged    <= {FW{1'b0}};
      pending   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      ovf       <= ovf_next;
      shadow    <= shadow_next;
      staged    <= frame_ok ? shadow_next : staged;
      pending   <= frame_ok | (pending & ~take);
      err_short <= frame_end & ~ovf_next & (cnt_next != FB_C);
      err_long  <= frame_end & ovf_next;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Launches staged LED frames to the serial driver, enforces the transmit dwell
// and optionally re-sends the current frame after an idle period.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = DEF_NUM_LEDS,
  parameter int BITS_PER_LED   = DEF_BITS_PER_LED,
  parameter int TX_CYCLES      = DEF_TX_CYCLES,
  parameter int REFRESH_CYCLES = 0,
  localparam int FW            = frame_width(NUM_LEDS, BITS_PER_LED)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          frame_end,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic [FW-1:0] data,
  output logic          data_rdy,
  output logic          busy,
  output logic          err_short,
  output logic          err_long
);

  localparam int MAXC = (TX_CYCLES > REFRESH_CYCLES) ? TX_CYCLES : REFRESH_CYCLES;
  localparam int DW   = $clog2(MAXC + 1);
  localparam logic [DW-1:0] TX_LAST      = DW'(TX_CYCLES - 1);
  localparam logic [DW-1:0] REFRESH_LAST = DW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
  localparam logic          REFRESH_EN   = (REFRESH_CYCLES > 0);

  led_state_e    state;
  led_state_e    state_next;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_next;
  logic [DW-1:0] idle_cnt;
  logic [DW-1:0] idle_next;
  logic          refresh_req;
  logic          refresh_next;
  logic [FW-1:0] data_next;
  logic          rdy_next;
  logic          busy_next;
  logic          take;
  logic [FW-1:0] staged;
  logic          pending;

  led_frame_assembler #(
    .NUM_LEDS     (NUM_LEDS),
    .BITS_PER_LED (BITS_PER_LED)
  ) u_assembler (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .take        (take),
    .staged      (staged),
    .pending     (pending),
    .err_short   (err_short),
    .err_long    (err_long)
  );

  // Refresh is raised as a request one cycle ahead of its launch, mirroring the
  // staging cycle of a received frame.
  always_comb begin
    state_next   = state;
    dwell_next   = dwell;
    idle_next    = idle_cnt;
    refresh_next = refresh_req;
    data_next    = data;
    rdy_next     = 1'b0;
    busy_next    = busy;
    take         = 1'b0;
    case (state)
      IDLE: begin
        if (pending || refresh_req) begin
          take         = pending;
          data_next    = pending ? staged : data;
          rdy_next     = 1'b1;
          busy_next    = 1'b1;
          dwell_next   = TX_LAST;
          idle_next    = DW'(0);
          refresh_next = 1'b0;
          state_next   = BUSY;
        end else if (REFRESH_EN && (idle_cnt == REFRESH_LAST)) begin
          refresh_next = 1'b1;
        end else begin
          idle_next = REFRESH_EN ? (idle_cnt + DW'(1)) : DW'(0);
        end
      end
      BUSY: begin
        if (dwell == DW'(0)) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          dwell_next = dwell - DW'(1);
        end
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and registered driver outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dwell       <= DW'(0);
      idle_cnt    <= DW'(0);
      refresh_req <= 1'b0;
      data        <= {FW{1'b0}};
      data_rdy    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      dwell       <= dwell_next;
      idle_cnt    <= idle_next;
      refresh_req <= refresh_next;
      data        <= data_next;
      data_rdy    <= rdy_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench: one instance without refresh (main checks) and one with
// REFRESH_CYCLES=50 for the periodic re-send behaviour.
module tb_led_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [71:0] data0, data1;
  logic        rdy0, rdy1, busy0, busy1;
  logic        es0, es1, el0, el1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  led_frame_scheduler #(.NUM_LEDS(3), .BITS_PER_LED(24), .TX_CYCLES(20), .REFRESH_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .byte_data(byte_data), .data(data0), .data_rdy(rdy0),
    .busy(busy0), .err_short(es0), .err_long(el0)
  );

  led_frame_scheduler #(.NUM_LEDS(3), .BITS_PER_LED(24), .TX_CYCLES(20), .REFRESH_CYCLES(50)) dut1 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_end(frame_end),
    .byte_valid(byte_valid), .byte_data(byte_data), .data(data1), .data_rdy(rdy1),
    .busy(busy1), .err_short(es1), .err_long(el1)
  );

  function automatic logic [71:0] mkframe(input logic [7:0] base);
    logic [71:0] f;
    f = 72'h0;
    for (int i = 0; i < 9; i++) f[71-8*i -: 8] = base + 8'(i);
    return f;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%018h expected=%018h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    frame_start = 1'b0;
    frame_end   = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
  endtask

  // First byte rides with frame_start; frame_end either with the last byte or one cycle later.
  // Returns at the negedge where frame_end has just been driven.
  task automatic send_frame(input int n, input logic [7:0] base, input logic fe_with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = (i == 0);
      byte_valid  = 1'b1;
      byte_data   = base + 8'(i);
      frame_end   = fe_with_last && (i == n - 1);
    end
    if (!fe_with_last) begin
      @(negedge clk);
      idle_in();
      frame_end = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chkd("reset_data", data0, 72'h0);
    chk1("reset_rdy", rdy0, 1'b0);
    chk1("reset_busy", busy0, 1'b0);
    chk1("reset_err_short", es0, 1'b0);
    chk1("reset_err_long", el0, 1'b0);
    reset = 1'b0;

    // Valid frame while IDLE: launch 2 cycles after frame_end, busy for 20 cycles
    send_frame(9, 8'h01, 1'b0);
    @(negedge clk); idle_in();
    chk1("valid_stage_rdy", rdy0, 1'b0);
    chkd("valid_stage_data", data0, 72'h0);
    @(negedge clk);
    chk1("valid_launch_rdy", rdy0, 1'b1);
    chkd("valid_launch_data", data0, 72'h010203040506070809);
    chk1("valid_launch_busy", busy0, 1'b1);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chk1("valid_busy_hold", busy0, 1'b1);
      chk1("valid_rdy_single", rdy0, 1'b0);
    end
    @(negedge clk);
    chk1("valid_busy_fall", busy0, 1'b0);

    // Short frame
    send_frame(5, 8'h10, 1'b0);
    @(negedge clk); idle_in();
    chk1("short_err", es0, 1'b1);
    chk1("short_no_long", el0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("short_err_single", es0, 1'b0);
      chk1("short_no_rdy", rdy0, 1'b0);
    end
    chkd("short_data_kept", data0, 72'h010203040506070809);

    // Long frame (10th byte overflows)
    send_frame(10, 8'h20, 1'b0);
    @(negedge clk); idle_in();
    chk1("long_err", el0, 1'b1);
    chk1("long_no_short", es0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("long_err_single", el0, 1'b0);
      chk1("long_no_rdy", rdy0, 1'b0);
    end
    chkd("long_data_kept", data0, 72'h010203040506070809);

    // Frames A and B completed during BUSY: only B launches, 21 cycles after C
    send_frame(9, 8'h31, 1'b0);
    @(negedge clk); idle_in();
    @(negedge clk);
    chk1("c_launch_rdy", rdy0, 1'b1);
    chkd("c_launch_data", data0, mkframe(8'h31));
    send_frame(9, 8'h41, 1'b1);
    send_frame(9, 8'h51, 1'b1);
    @(negedge clk); idle_in();
    chk1("busy_ab_busy", busy0, 1'b1);
    chkd("busy_ab_data_held", data0, mkframe(8'h31));
    chk1("busy_ab_no_rdy", rdy0, 1'b0);
    @(negedge clk);
    chk1("busy_ab_fall", busy0, 1'b0);
    chk1("busy_ab_gap_rdy", rdy0, 1'b0);
    @(negedge clk);
    chk1("b_launch_rdy", rdy0, 1'b1);
    chkd("b_launch_data", data0, mkframe(8'h51));
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      chkd("b_data_hold", data0, mkframe(8'h51));
      chk1("b_no_relaunch", rdy0, 1'b0);
    end
    @(negedge clk);
    chk1("b_busy_fall", busy0, 1'b0);
    @(negedge clk);
    chk1("no_launch_of_a", rdy0, 1'b0);

    // Reset mid-BUSY
    send_frame(9, 8'h81, 1'b0);
    @(negedge clk); idle_in();
    @(negedge clk);
    chkd("pre_reset_data", data0, mkframe(8'h81));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkd("rst_busy_data", data0, 72'h0);
    chk1("rst_busy_busy", busy0, 1'b0);
    chk1("rst_busy_rdy", rdy0, 1'b0);

    // Reset mid-frame: the partial bytes are lost, so a bare frame_end is short
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      frame_start = (i == 0);
      byte_valid  = 1'b1;
      byte_data   = 8'h91 + 8'(i);
    end
    @(negedge clk); idle_in(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chkd("rst_frame_data", data0, 72'h0);
    chk1("rst_frame_busy", busy0, 1'b0);
    chk1("rst_frame_err_short", es0, 1'b0);
    chk1("rst_frame_err_long", el0, 1'b0);
    frame_end = 1'b1;
    @(negedge clk); idle_in();
    chk1("rst_partial_lost", es0, 1'b1);
    chk1("rst_partial_no_rdy", rdy0, 1'b0);

    // 9th byte coincident with frame_end is a valid frame
    send_frame(9, 8'hA1, 1'b1);
    @(negedge clk); idle_in();
    chk1("simul_stage_rdy", rdy0, 1'b0);
    chk1("simul_no_short", es0, 1'b0);
    @(negedge clk);
    chk1("simul_launch_rdy", rdy0, 1'b1);
    chkd("simul_launch_data", data0, mkframe(8'hA1));

    // Refresh: dut1 repeats every 71 cycles, dut0 never repeats
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    send_frame(9, 8'hB1, 1'b0);
    @(negedge clk); idle_in();
    @(negedge clk);
    chk1("ref_launch_rdy1", rdy1, 1'b1);
    chk1("ref_launch_rdy0", rdy0, 1'b1);
    chkd("ref_launch_data1", data1, mkframe(8'hB1));
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 71; k++) begin
        @(negedge clk);
        chk1("ref_period_rdy1", rdy1, (k == 71));
        chk1("ref_disabled_rdy0", rdy0, 1'b0);
      end
      chkd("ref_repeat_data1", data1, mkframe(8'hB1));
      chk1("ref_repeat_busy1", busy1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
